// File: rtl/norm_writer.sv
// rtl/norm_writer.sv - frame buffer with max tracking between crop filter and normalizing reader
//
// Captures one OUT_ROWS*OUT_COLS frame of 8-bit pixels from an AXI-Stream slave,
// tracks its maximum pixel, then replays the frame in capture order on an
// AXI-Stream master.
//
// Ports:
//   clk, srst                 clock, synchronous active-high reset
//   ap_start/ap_ready/ap_done  pipeline start/ready/done handshake
//   s_axis_t{valid,ready,data,last}  pixel input stream (crop filter)
//   m_axis_t{valid,ready,data}       pixel replay stream (reader stage)
//   norm_denominator, norm_valid     frame max (clamped >=1) and its qualifier
//   err_tlast                        sticky tlast-position mismatch flag

module norm_writer #(
  parameter int OUT_ROWS = 10,
  parameter int OUT_COLS = 10
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       ap_start,
  output logic       ap_ready,
  output logic       ap_done,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tlast,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic [7:0] norm_denominator,
  output logic       norm_valid,
  output logic       err_tlast
);

  localparam int N  = OUT_ROWS * OUT_COLS;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(N - 1);
  localparam logic [AW:0] N_CNT    = (AW+1)'(N);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REPLAY  = 2'd2
  } state_e;

  state_e      state_q, state_d;

  logic [AW:0] wr_cnt_q;
  logic [AW:0] rd_addr_q;
  logic [AW:0] rd_cnt_q;
  logic [7:0]  max_q;
  logic [7:0]  den_q;
  logic        norm_valid_q;
  logic        err_q;
  logic        done_q;

  logic [7:0]  mem [N];
  logic [7:0]  rdata_q;
  logic        rd_pend_q;

  // Two-entry skid buffer; skid0_q is always the head presented on m_axis_tdata.
  logic [1:0]  skid_cnt_q;
  logic [7:0]  skid0_q;
  logic [7:0]  skid1_q;

  logic        start_acc;
  logic        cap_beat;
  logic        cap_last;
  logic [7:0]  cap_max;
  logic        out_pop;
  logic        out_last;
  logic [1:0]  fill_next;
  logic        rd_issue;

  assign ap_ready         = (state_q == S_IDLE);
  assign ap_done          = done_q;
  assign s_axis_tready    = (state_q == S_CAPTURE);
  assign m_axis_tvalid    = (state_q == S_REPLAY) && (skid_cnt_q != 2'd0);
  assign m_axis_tdata     = skid0_q;
  assign norm_denominator = den_q;
  assign norm_valid       = norm_valid_q;
  assign err_tlast        = err_q;

  assign start_acc = (state_q == S_IDLE) && ap_start;
  assign cap_beat  = (state_q == S_CAPTURE) && s_axis_tvalid;
  assign cap_last  = cap_beat && (wr_cnt_q == LAST_IDX);
  assign cap_max   = (s_axis_tdata > max_q) ? s_axis_tdata : max_q;
  assign out_pop   = m_axis_tvalid && m_axis_tready;
  assign out_last  = out_pop && (rd_cnt_q == LAST_IDX);

  // Occupancy the skid buffer will have next cycle, counting the read in flight.
  // A new read is issued only if that leaves room for its data one cycle later.
  assign fill_next = skid_cnt_q - {1'b0, out_pop} + {1'b0, rd_pend_q};
  assign rd_issue  = (state_q == S_REPLAY) && (rd_addr_q < N_CNT) && (fill_next <= 2'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (ap_start) state_d = S_CAPTURE;
      S_CAPTURE: if (cap_last) state_d = S_REPLAY;
      S_REPLAY:  if (out_last) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Frame RAM: write port in CAPTURE, registered read port in REPLAY.
  always_ff @(posedge clk) begin
    if (cap_beat) begin
      mem[wr_cnt_q[AW-1:0]] <= s_axis_tdata;
    end
    if (rd_issue) begin
      rdata_q <= mem[rd_addr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= S_IDLE;
      wr_cnt_q     <= '0;
      rd_addr_q    <= '0;
      rd_cnt_q     <= '0;
      max_q        <= 8'd0;
      den_q        <= 8'd1;
      norm_valid_q <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      rd_pend_q    <= 1'b0;
      skid_cnt_q   <= 2'd0;
      skid0_q      <= 8'd0;
      skid1_q      <= 8'd0;
    end else begin
      state_q   <= state_d;
      done_q    <= out_last;
      rd_pend_q <= rd_issue;

      if (start_acc) begin
        wr_cnt_q     <= '0;
        rd_addr_q    <= '0;
        rd_cnt_q     <= '0;
        max_q        <= 8'd0;
        err_q        <= 1'b0;
        norm_valid_q <= 1'b0;
        skid_cnt_q   <= 2'd0;
      end

      if (cap_beat) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        max_q    <= cap_max;
        // tlast must be high on the final beat and only there.
        if (s_axis_tlast != (wr_cnt_q == LAST_IDX)) begin
          err_q <= 1'b1;
        end
      end

      if (cap_last) begin
        den_q        <= (cap_max == 8'd0) ? 8'd1 : cap_max;
        norm_valid_q <= 1'b1;
      end

      if (rd_issue) begin
        rd_addr_q <= rd_addr_q + 1'b1;
      end

      if (out_pop) begin
        rd_cnt_q <= rd_cnt_q + 1'b1;
      end

      if (rd_pend_q && out_pop) begin
        if (skid_cnt_q == 2'd2) begin
          skid0_q <= skid1_q;
          skid1_q <= rdata_q;
        end else begin
          skid0_q <= rdata_q;
        end
      end else if (out_pop) begin
        skid0_q    <= skid1_q;
        skid_cnt_q <= skid_cnt_q - 2'd1;
      end else if (rd_pend_q) begin
        if (skid_cnt_q == 2'd0) begin
          skid0_q <= rdata_q;
        end else begin
          skid1_q <= rdata_q;
        end
        skid_cnt_q <= skid_cnt_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_norm_writer.sv
// tb/tb_norm_writer.sv - self-checking bench for norm_writer (4x4 frame)

module tb_norm_writer;

  localparam int R = 4;
  localparam int C = 4;
  localparam int N = R * C;

  logic       clk = 1'b0;
  logic       srst;
  logic       ap_start;
  logic       ap_ready;
  logic       ap_done;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tlast;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic [7:0] norm_denominator;
  logic       norm_valid;
  logic       err_tlast;

  int         checks = 0;
  int         errors = 0;

  logic [7:0] frame [N];
  logic [7:0] exp_den;
  logic [7:0] prev_den;
  logic       exp_err;

  norm_writer #(.OUT_ROWS(R), .OUT_COLS(C)) dut (
    .clk              (clk),
    .srst             (srst),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tready    (s_axis_tready),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tlast     (s_axis_tlast),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tdata     (m_axis_tdata),
    .norm_denominator (norm_denominator),
    .norm_valid       (norm_valid),
    .err_tlast        (err_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_den();
    int m = 0;
    for (int i = 0; i < N; i++) if (int'(frame[i]) > m) m = int'(frame[i]);
    return (m == 0) ? 8'd1 : 8'(m);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ap_ready"}, ap_ready, 1);
    chk({tag, "_ap_done"}, ap_done, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_den"}, norm_denominator, 1);
    chk({tag, "_norm_valid"}, norm_valid, 0);
    chk({tag, "_err_tlast"}, err_tlast, 0);
    prev_den = 8'd1;
  endtask

  // Called at the negedge right after ap_start was accepted.
  task automatic chk_started(input string tag);
    chk({tag, "_ap_ready_low"}, ap_ready, 0);
    chk({tag, "_s_tready_high"}, s_axis_tready, 1);
    chk({tag, "_nv_cleared"}, norm_valid, 0);
    chk({tag, "_err_cleared"}, err_tlast, 0);
    chk({tag, "_den_held"}, norm_denominator, prev_den);
  endtask

  task automatic start_frame();
    @(negedge clk);
    ap_start = 1'b1;
    chk("start_ready", ap_ready, 1);
    @(negedge clk);
    ap_start = 1'b0;
    chk_started("start");
  endtask

  // Sends nb beats of frame[]; tlast on beat tlast_pos; optional random tvalid gaps;
  // ap_start is pulsed while beat pulse_at is being offered.
  task automatic send_frame(input int nb, input int tlast_pos, input bit gaps, input int pulse_at);
    int i = 0;
    int guard = 0;
    bit v;
    while (i < nb && guard < 1000) begin
      @(negedge clk);
      guard++;
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_tvalid = v;
      s_axis_tdata  = frame[i];
      s_axis_tlast  = (i == tlast_pos);
      ap_start      = (i == pulse_at);
      if (v && s_axis_tready) i++;
    end
    chk("send_beats", i, nb);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    ap_start      = 1'b0;
    if (nb == N) begin
      exp_den = model_den();
      exp_err = (tlast_pos != N - 1);
      chk("replay_entry_s_tready", s_axis_tready, 0);
      chk("replay_entry_nv", norm_valid, 1);
      chk("replay_entry_den", norm_denominator, exp_den);
      chk("replay_entry_err", err_tlast, exp_err);
    end
  endtask

  // Receives the replay, starting at the REPLAY-entry negedge.
  task automatic recv_frame(input bit rnd, input int pulse_at, input bit start_in_done);
    int k = 0;
    int cyc = 0;
    int first = -1;
    bit stall = 1'b0;
    logic [7:0] held = 8'd0;
    while (k < N && cyc < 2000) begin
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ap_start = (k == pulse_at);
      if (stall) begin
        chk("stall_tvalid_held", m_axis_tvalid, 1);
        chk("stall_tdata_held", m_axis_tdata, held);
      end
      if (m_axis_tvalid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_valid_latency_ok", (first <= 2), 1);
        end
        if (m_axis_tready) begin
          chk($sformatf("beat%0d_data", k), m_axis_tdata, frame[k]);
          if (!rnd) chk($sformatf("beat%0d_no_bubble", k), cyc, first + k);
          k++;
          stall = 1'b0;
        end else begin
          stall = 1'b1;
          held = m_axis_tdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    ap_start = 1'b0;
    m_axis_tready = 1'b0;
    chk("recv_beats", k, N);
    chk("done_pulse", ap_done, 1);
    chk("done_ready", ap_ready, 1);
    chk("done_tvalid_low", m_axis_tvalid, 0);
    chk("done_nv", norm_valid, 1);
    chk("done_den", norm_denominator, exp_den);
    chk("done_err", err_tlast, exp_err);
    prev_den = exp_den;
    if (start_in_done) begin
      ap_start = 1'b1;
      @(negedge clk);
      ap_start = 1'b0;
      chk("restart_done_low", ap_done, 0);
      chk_started("restart");
    end else begin
      @(negedge clk);
      chk("done_one_cycle", ap_done, 0);
      chk("idle_ready", ap_ready, 1);
    end
  endtask

  initial begin
    srst = 1'b1;
    ap_start = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'd0;
    s_axis_tlast = 1'b0;
    m_axis_tready = 1'b0;
    exp_den = 8'd1;
    exp_err = 1'b0;
    prev_den = 8'd1;
    repeat (3) @(negedge clk);
    chk_reset("reset");
    srst = 1'b0;

    // 1: ramp 0..15
    for (int i = 0; i < N; i++) frame[i] = 8'(i);
    start_frame();
    send_frame(N, N - 1, 1'b0, -1);
    chk("ramp_den_15", norm_denominator, 15);
    recv_frame(1'b0, -1, 1'b0);

    // 2: all-zero frame clamps denominator to 1
    for (int i = 0; i < N; i++) frame[i] = 8'd0;
    start_frame();
    send_frame(N, N - 1, 1'b0, -1);
    recv_frame(1'b0, -1, 1'b0);

    // 3: single 255 with input gaps and random backpressure
    for (int i = 0; i < N; i++) frame[i] = 8'($urandom_range(0, 254));
    frame[$urandom_range(0, N - 1)] = 8'd255;
    start_frame();
    send_frame(N, N - 1, 1'b1, -1);
    chk("max255_den", norm_denominator, 255);
    recv_frame(1'b1, -1, 1'b0);

    // 4: early tlast on beat 7
    fill_random();
    start_frame();
    send_frame(N, 7, 1'b1, -1);
    recv_frame(1'b1, -1, 1'b0);

    // 5: ap_start ignored in CAPTURE/REPLAY, accepted in the ap_done cycle
    fill_random();
    start_frame();
    send_frame(N, N - 1, 1'b0, 5);
    recv_frame(1'b1, 3, 1'b1);
    fill_random();
    send_frame(N, N - 1, 1'b0, -1);
    recv_frame(1'b0, -1, 1'b0);

    // 6: srst after 9 capture beats aborts, then a clean frame
    fill_random();
    start_frame();
    send_frame(9, N - 1, 1'b0, -1);
    srst = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    srst = 1'b0;
    fill_random();
    start_frame();
    send_frame(N, N - 1, 1'b1, -1);
    recv_frame(1'b1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
